// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter
// Shares the single SPI external-memory controller between the data port (D,
// load/store) and the fetch port (I). One controller transaction at a time,
// one-cycle ack per completed access, watchdog abort for hung transfers.
//
// Build option: define MEM_ARB_RR_EN to replace fixed D-over-I priority on
// ties with round robin driven by a 1-bit last-grant register.
//
// state | meaning
// IDLE  | no transaction; sample requests and pick a winner
// ISSUE | first cycle of mem_req; watchdog cleared
// WAIT  | mem_req held; waiting for mem_ready or the watchdog limit
// DONE  | ack pulse to the granted port with rdata/err valid

module ext_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              reset,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,

  output logic [DATA_W-1:0] rdata,
  output logic              err,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_abort,

  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so the
  // declarations stay legal in that build.
  localparam bit                WD_EN    = (TIMEOUT != 0);
  localparam int                CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WD_EN ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  wd_cnt;
  logic              grant_d;     // 1: current transaction belongs to the data port

  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_abort_q;

  logic              any_req;
  logic              tie_to_d;
  logic              pick_d;
  logic [ADDR_W-1:0] pick_addr;
  logic              pick_mmio;

  assign any_req = d_req | i_req;

`ifdef MEM_ARB_RR_EN
  logic last_grant_d;             // 1: last grant went to D; reset value means I

  // Remember the last winner (MMIO rejects included) so ties alternate
  always_ff @(posedge CLK) begin
    if (!reset) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_grant_d <= pick_d;
    end
  end

  assign tie_to_d = ~last_grant_d;
`else
  assign tie_to_d = 1'b1;
`endif

  // Winner selection: a lone request always wins, ties follow the tie rule
  always_comb begin
    pick_d = d_req;
    if (d_req && i_req) begin
      pick_d = tie_to_d;
    end
  end

  assign pick_addr = pick_d ? d_addr : i_addr;
  assign pick_mmio = pick_addr[ADDR_W-1];

  // Sequencing FSM with watchdog and result registers
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      grant_d     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_abort_q <= 1'b0;
    end else begin
      mem_abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d <= pick_d;
            if (pick_mmio) begin
              // MMIO space is not behind this controller; reject without a transfer
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= DONE;
            end else begin
              mem_we_q    <= pick_d & d_we;
              mem_addr_q  <= pick_addr;
              mem_wdata_q <= pick_d ? d_wdata : '0;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
            state   <= DONE;
          end else if (WD_EN && (wd_cnt == CNT_LAST)) begin
            mem_abort_q <= 1'b1;
            rdata_q     <= '0;
            err_q       <= 1'b1;
            state       <= DONE;
          end else if (wd_cnt != CNT_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign d_ack     = (state == DONE) &&  grant_d;
  assign i_ack     = (state == DONE) && !grant_d;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_req   = (state == ISSUE) || (state == WAIT);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_abort = mem_abort_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: queue-driven requesters, a scripted or random
// controller responder, and a timeline-based reference model checked every cycle.
module tb_ext_mem_arbiter;

  localparam int TB_TIMEOUT = 16;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int          dly;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        CLK;
  logic        reset;
  logic        d_req, d_we, d_ack;
  logic [31:0] d_addr, d_wdata;
  logic        i_req, i_ack;
  logic [31:0] i_addr;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req, mem_we, mem_abort, mem_ready, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  ext_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_abort(mem_abort),
    .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int     checks = 0;
  int     errors = 0;
  longint now = 0;

  req_t   dq[$];
  req_t   iq[$];
  bit     flush = 1'b0;
  longint d_raise_cyc = 0, i_raise_cyc = 0;

  bit          resp_rand = 1'b0;
  int          resp_delay = 2;
  logic [31:0] resp_data = 32'h0;
  int          req_cnt = 0;

  // observations recorded by the compare process
  longint      d_ack_cyc = 0, i_ack_cyc = 0;
  logic [31:0] d_ack_rdata = 0, d_snap_addr = 0, d_snap_wdata = 0;
  logic        d_ack_err = 0, d_snap_we = 0;
  int          ack_count = 0, mreq_cycles = 0, abort_cycles = 0;
  bit          ack_log[$];

  // reference model state (timeline of the current transaction)
  bit          m_valid = 0, m_in_reset = 0, m_active = 0, m_is_d = 0, m_mmio = 0, m_abort = 0, m_last_d = 0;
  longint      m_start = 0, m_done = -1;
  logic [31:0] e_rdata = 0, e_mem_addr = 0, e_mem_wdata = 0;
  logic        e_err_flag = 0, e_mem_we = 0;
  logic        e_busy = 0, e_mem_req = 0, e_d_ack = 0, e_i_ack = 0, e_abort = 0, e_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, now, act, exp);
    end
  endtask

  task automatic bound_chk(input string name, input int n, input int lim);
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, n, lim);
    end
  endtask

  task automatic push_d(input int dly, input logic we, input logic [31:0] a, input logic [31:0] w);
    req_t r;
    r.dly = dly; r.we = we; r.addr = a; r.wdata = w;
    dq.push_back(r);
  endtask

  task automatic push_i(input int dly, input logic [31:0] a);
    req_t r;
    r.dly = dly; r.we = 1'b0; r.addr = a; r.wdata = 32'h0;
    iq.push_back(r);
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    while (n < lim && (dq.size() > 0 || iq.size() > 0 || d_req || i_req || m_active)) begin
      @(negedge CLK);
      n++;
    end
    bound_chk(name, n, lim);
    repeat (2) @(negedge CLK);
  endtask

  // data-port requester: holds req until its ack
  initial begin
    req_t r;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    forever begin
      @(negedge CLK);
      if (flush) begin
        d_req = 0;
        dq.delete();
      end else if (d_req) begin
        if (d_ack) d_req = 0;
      end else if (dq.size() > 0) begin
        r = dq.pop_front();
        if (r.dly > 0) begin
          r.dly = r.dly - 1;
          dq.push_front(r);
        end else begin
          d_req = 1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata;
          d_raise_cyc = now;
        end
      end
    end
  end

  // fetch-port requester
  initial begin
    req_t r;
    i_req = 0; i_addr = 0;
    forever begin
      @(negedge CLK);
      if (flush) begin
        i_req = 0;
        iq.delete();
      end else if (i_req) begin
        if (i_ack) i_req = 0;
      end else if (iq.size() > 0) begin
        r = iq.pop_front();
        if (r.dly > 0) begin
          r.dly = r.dly - 1;
          iq.push_front(r);
        end else begin
          i_req = 1; i_addr = r.addr;
          i_raise_cyc = now;
        end
      end
    end
  end

  // controller responder: scripted (ready on the Nth mem_req cycle, 0 = never) or random
  initial begin
    mem_ready = 0; mem_rdata = 0;
    forever begin
      @(negedge CLK);
      if (mem_req) req_cnt++; else req_cnt = 0;
      if (resp_rand) begin
        mem_ready = ($urandom_range(0, 99) < 15);
        mem_rdata = $urandom;
      end else begin
        mem_ready = (resp_delay != 0) && (req_cnt == resp_delay);
        mem_rdata = resp_data;
      end
    end
  end

  // reference model: a grant starts a timeline; the controller may finish from
  // two cycles after the grant on; the watchdog fires TIMEOUT cycles after that point
  initial begin
    logic        take_d;
    logic [31:0] a;
    forever begin
      @(posedge CLK);
      if (!reset) begin
        m_valid = 1; m_in_reset = 1; m_active = 0; m_last_d = 0; m_done = -1;
        e_rdata = 0; e_err_flag = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
      end else begin
        m_in_reset = 0;
        if (!m_active) begin
          if (d_req || i_req) begin
            if (d_req && i_req) take_d = RR ? !m_last_d : 1'b1;
            else take_d = d_req;
            m_active = 1; m_is_d = take_d; m_last_d = take_d; m_start = now; m_abort = 0;
            a = take_d ? d_addr : i_addr;
            if (a[31]) begin
              m_mmio = 1; m_done = now + 1; e_rdata = 0; e_err_flag = 1;
            end else begin
              m_mmio = 0; m_done = -1;
              e_mem_we = take_d && d_we; e_mem_addr = a; e_mem_wdata = take_d ? d_wdata : 32'h0;
            end
          end
        end else if (m_done < 0) begin
          if (now >= m_start + 2) begin
            if (mem_ready) begin
              m_done = now + 1; e_rdata = mem_rdata; e_err_flag = 0;
            end else if (now - (m_start + 2) == TB_TIMEOUT - 1) begin
              m_done = now + 1; m_abort = 1; e_rdata = 0; e_err_flag = 1;
            end
          end
        end else if (now == m_done) begin
          m_active = 0;
        end
      end
      e_busy    = m_active;
      e_mem_req = m_active && !m_mmio && (m_done < 0);
      e_d_ack   = m_active && (m_done == now + 1) && m_is_d;
      e_i_ack   = m_active && (m_done == now + 1) && !m_is_d;
      e_abort   = (e_d_ack || e_i_ack) && m_abort;
      e_err     = (e_d_ack || e_i_ack) && e_err_flag;
      now++;
    end
  end

  // compare DUT with the model every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge CLK);
      if (m_valid) begin
        chk("busy", busy, e_busy);
        chk("mem_req", mem_req, e_mem_req);
        chk("d_ack", d_ack, e_d_ack);
        chk("i_ack", i_ack, e_i_ack);
        chk("mem_abort", mem_abort, e_abort);
        chk("err", err, e_err);
        chk("mem_we", mem_we, e_mem_we);
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        if (e_d_ack || e_i_ack || m_in_reset) chk("rdata", rdata, e_rdata);
      end
      if (mem_req) mreq_cycles++;
      if (mem_abort) abort_cycles++;
      if (d_ack) begin
        d_ack_cyc = now; d_ack_rdata = rdata; d_ack_err = err;
        d_snap_we = mem_we; d_snap_addr = mem_addr; d_snap_wdata = mem_wdata;
        ack_count++; ack_log.push_back(1'b1);
      end
      if (i_ack) begin
        i_ack_cyc = now;
        ack_count++; ack_log.push_back(1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, base, mr0, ab0;
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("reset_busy", busy, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_mem_addr", mem_addr, 0);

    // reset in the middle of WAIT: silent abort
    resp_rand = 0; resp_delay = 0;
    mr0 = mreq_cycles;
    push_d(0, 1'b0, 32'h300, 32'h0);
    n = 0;
    while (mreq_cycles - mr0 < 5 && n < 50) begin @(negedge CLK); n++; end
    bound_chk("t1_reach_wait", n, 50);
    base = ack_count;
    flush = 1; reset = 0;
    repeat (3) @(negedge CLK);
    reset = 1; flush = 0;
    repeat (5) @(negedge CLK);
    chk("t1_no_ack", ack_count, base);
    chk("t1_no_abort", abort_cycles, 0);
    chk("t1_busy", busy, 0);
    chk("t1_mem_req", mem_req, 0);
    chk("t1_mem_addr", mem_addr, 0);

    // ties straight after reset: D wins both ways (last grant resets to I)
    resp_delay = 2; resp_data = 32'hA5A5_0001;
    ack_log.delete();
    push_d(0, 1'b0, 32'h10, 0); push_i(0, 32'h20);
    wait_idle("t3a_idle", 200);
    push_d(0, 1'b0, 32'h14, 0); push_i(0, 32'h24);
    wait_idle("t3b_idle", 200);
    chk("t3_log_size", ack_log.size(), 4);
    chk("t3_log0", ack_log[0], 1);
    chk("t3_log1", ack_log[1], 0);
    chk("t3_log2", ack_log[2], 1);
    chk("t3_log3", ack_log[3], 0);

    // lone D, then a tie: round robin now favours I
    ack_log.delete();
    push_d(0, 1'b0, 32'h18, 0);
    wait_idle("t3c_idle", 200);
    push_d(0, 1'b0, 32'h1C, 0); push_i(0, 32'h28);
    wait_idle("t3d_idle", 200);
    chk("t3c_log_size", ack_log.size(), 3);
    chk("t3c_tie_first", ack_log[1], RR ? 0 : 1);
    chk("t3c_tie_second", ack_log[2], RR ? 1 : 0);

    // read with ready in the sixth WAIT cycle
    resp_delay = 7; resp_data = 32'hDEADBEEF;
    push_d(0, 1'b0, 32'h100, 0);
    wait_idle("t2_idle", 200);
    chk("t2_latency", d_ack_cyc - d_raise_cyc, 8);
    chk("t2_rdata", d_ack_rdata, 32'hDEADBEEF);
    chk("t2_err", d_ack_err, 0);
    chk("t2_mem_addr", d_snap_addr, 32'h100);
    chk("t2_mem_we", d_snap_we, 0);

    // watchdog timeout
    resp_delay = 0;
    ab0 = abort_cycles;
    push_d(0, 1'b0, 32'h200, 0);
    wait_idle("t4_idle", 200);
    chk("t4_latency", d_ack_cyc - d_raise_cyc, 18);
    chk("t4_err", d_ack_err, 1);
    chk("t4_rdata", d_ack_rdata, 0);
    chk("t4_abort_pulses", abort_cycles - ab0, 1);

    // MMIO reject
    resp_delay = 2;
    mr0 = mreq_cycles;
    push_d(0, 1'b0, 32'h8000_0004, 0);
    wait_idle("t5_idle", 200);
    chk("t5_no_mem_req", mreq_cycles - mr0, 0);
    chk("t5_latency", d_ack_cyc - d_raise_cyc, 1);
    chk("t5_err", d_ack_err, 1);
    chk("t5_rdata", d_ack_rdata, 0);

    // write with a fetch pending
    resp_delay = 3; resp_data = 32'h0BAD_F00D;
    ack_log.delete();
    push_i(0, 32'h80);
    push_d(0, 1'b1, 32'h40, 32'h12345678);
    wait_idle("t6_idle", 200);
    chk("t6_log_size", ack_log.size(), 2);
    chk("t6_first", ack_log[0], RR ? 0 : 1);
    chk("t6_mem_we", d_snap_we, 1);
    chk("t6_mem_wdata", d_snap_wdata, 32'h12345678);
    chk("t6_mem_addr", d_snap_addr, 32'h40);

    // random traffic against the model
    resp_rand = 1;
    for (int k = 0; k < 40; k++) begin
      push_d($urandom_range(0, 3), 1'($urandom_range(0, 1)),
             {($urandom_range(0, 9) == 0), 29'($urandom), 2'b00}, $urandom);
      push_i($urandom_range(0, 3), {($urandom_range(0, 9) == 0), 29'($urandom), 2'b00});
    end
    wait_idle("rand_idle", 6000);
    resp_rand = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
